// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, FSM states and size decode for the LSU
// Contents:
//   F3_* localparams  RISC-V load/store width encodings
//   state_t           IDLE / BUS / RESP
//   size_bytes()      funct3 -> transfer size in bytes
//   f3_legal()        funct3 legality for loads/stores on RV32 or RV64
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Low two funct3 bits encode log2 of the access size for every width.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load, input logic rv64);
    if (is_load) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
        F3_LD, F3_LWU:                       return rv64;
        default:                             return 1'b0;
      endcase
    end else begin
      case (f3)
        F3_SB, F3_SH, F3_SW: return 1'b1;
        F3_SD:               return rv64;
        default:             return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// rtl/lsu_fmt.sv - combinational byte-lane select, store replication and load extension
// Ports:
//   req_funct3, req_off  request width and address offset (store side)
//   st_data              store source register
//   sel, wdata           byte lane select and lane-replicated store data
//   ld_funct3, ld_off    captured width and offset of the pending load
//   rdata                raw bus read data
//   ld_data              lane-extracted, sign/zero-extended load result
module lsu_fmt
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SEL_W = XLEN / 8,
  localparam int OFF_W = $clog2(SEL_W)
) (
  input  logic [2:0]       req_funct3,
  input  logic [OFF_W-1:0] req_off,
  input  logic [XLEN-1:0]  st_data,
  output logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  wdata,
  input  logic [2:0]       ld_funct3,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [XLEN-1:0] lane;

  // Move the addressed lane down to bit 0 before extending.
  assign lane = rdata >> {ld_off, 3'b000};

  always_comb begin
    sel   = '0;
    wdata = '0;
    case (req_funct3[1:0])
      2'b00: begin
        sel   = SEL_W'(1) << req_off;
        wdata = {SEL_W{st_data[7:0]}};
      end
      2'b01: begin
        sel   = SEL_W'(3) << req_off;
        wdata = {(SEL_W / 2){st_data[15:0]}};
      end
      2'b10: begin
        sel   = SEL_W'(15) << req_off;
        wdata = {(XLEN / 32){st_data[31:0]}};
      end
      default: begin
        sel   = '1;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_data = lane;
    case (ld_funct3)
      F3_LB:   ld_data = XLEN'($signed(lane[7:0]));
      F3_LH:   ld_data = XLEN'($signed(lane[15:0]));
      F3_LW:   ld_data = XLEN'($signed(lane[31:0]));
      F3_LBU:  ld_data = XLEN'(lane[7:0]);
      F3_LHU:  ld_data = XLEN'(lane[15:0]);
      F3_LWU:  ld_data = XLEN'(lane[31:0]);
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - sequential load/store unit driving one Wishbone B4 classic cycle per request
// Optional feature macro: LSU_TIMEOUT_EN (bus-ack watchdog of TIMEOUT_CYCLES cycles).
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   req_valid_i/req_ready_o        request handshake (ready only in IDLE)
//   is_load_i, is_store_i          request kind (exactly one must be set)
//   funct3_i, addr_i, st_data_i    width encoding, effective address, store data
//   kill_i                         flush; suppresses the pending response
//   resp_valid_o                   one-cycle completion pulse
//   ld_data_o, e_*_o               load result and exception flags (valid with resp_valid_o)
//   wbm_*                          Wishbone master interface
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W = XLEN / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  st_data_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  output logic [XLEN-1:0]  ld_data_o,
  output logic             e_ld_addr_mis_o,
  output logic             e_st_addr_mis_o,
  output logic             e_ld_access_o,
  output logic             e_st_access_o,
  output logic [XLEN-1:0]  wbm_addr_o,
  output logic [XLEN-1:0]  wbm_dat_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  input  logic [XLEN-1:0]  wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  localparam int   OFF_W = $clog2(SEL_W);
  localparam logic RV64  = (XLEN == 64);

  state_t state_q, state_d;

  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic [SEL_W-1:0] sel_q;
  logic [XLEN-1:0]  addr_q, wdat_q, ld_data_q;
  logic             load_q, we_q, killed_q;
  logic             lmis_q, smis_q, lacc_q, sacc_q;

  logic [OFF_W-1:0] req_off;
  logic [SEL_W-1:0] fmt_sel;
  logic [XLEN-1:0]  fmt_wdata, fmt_ld;
  logic             accept, legal, mis, timeout, bus_fault;
  logic             upd;
  logic [XLEN-1:0]  nxt_ld;
  logic             nxt_lmis, nxt_smis, nxt_lacc, nxt_sacc;

  assign req_off = addr_i[OFF_W-1:0];
  assign accept  = (state_q == IDLE) && req_valid_i && (is_load_i ^ is_store_i);
  assign legal   = f3_legal(funct3_i, is_load_i, RV64);
  assign mis     = |(req_off & OFF_W'(size_bytes(funct3_i) - 4'd1));

  lsu_fmt #(.XLEN(XLEN)) u_fmt (
    .req_funct3 (funct3_i),
    .req_off    (req_off),
    .st_data    (st_data_i),
    .sel        (fmt_sel),
    .wdata      (fmt_wdata),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .rdata      (wbm_dat_i),
    .ld_data    (fmt_ld)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;

  // Held at zero outside BUS, so every bus cycle starts counting from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                tmo_q <= '0;
    else if (state_q != BUS)  tmo_q <= '0;
    else                      tmo_q <= tmo_q + 1'b1;
  end

  assign timeout = (state_q == BUS) && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: BUS waits for ack/err indefinitely.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Error wins over a simultaneous ack; a watchdog expiry counts as an error.
  assign bus_fault = wbm_err_i | timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    upd      = 1'b0;
    nxt_ld   = '0;
    nxt_lmis = 1'b0;
    nxt_smis = 1'b0;
    nxt_lacc = 1'b0;
    nxt_sacc = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal || mis) begin
            state_d  = RESP;
            upd      = !kill_i;
            nxt_lmis = legal && mis && is_load_i;
            nxt_smis = legal && mis && is_store_i;
            nxt_lacc = !legal && is_load_i;
            nxt_sacc = !legal && is_store_i;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (wbm_ack_i || bus_fault) begin
          state_d  = RESP;
          upd      = !(killed_q || kill_i);
          nxt_lacc = bus_fault && load_q;
          nxt_sacc = bus_fault && !load_q;
          nxt_ld   = (load_q && !bus_fault) ? fmt_ld : '0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f3_q      <= '0;
      off_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      load_q    <= 1'b0;
      we_q      <= 1'b0;
      killed_q  <= 1'b0;
      ld_data_q <= '0;
      lmis_q    <= 1'b0;
      smis_q    <= 1'b0;
      lacc_q    <= 1'b0;
      sacc_q    <= 1'b0;
    end else begin
      if (accept) begin
        f3_q     <= funct3_i;
        off_q    <= req_off;
        sel_q    <= fmt_sel;
        addr_q   <= {addr_i[XLEN-1:OFF_W], OFF_W'(0)};
        wdat_q   <= fmt_wdata;
        load_q   <= is_load_i;
        we_q     <= is_store_i;
        killed_q <= kill_i;
      end else if (state_q == BUS && kill_i) begin
        // Sticky: the bus cycle runs to completion but its response is dropped.
        killed_q <= 1'b1;
      end
      if (upd) begin
        ld_data_q <= nxt_ld;
        lmis_q    <= nxt_lmis;
        smis_q    <= nxt_smis;
        lacc_q    <= nxt_lacc;
        sacc_q    <= nxt_sacc;
      end
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign resp_valid_o    = (state_q == RESP) && !killed_q && !kill_i;
  assign ld_data_o       = ld_data_q;
  assign e_ld_addr_mis_o = lmis_q;
  assign e_st_addr_mis_o = smis_q;
  assign e_ld_access_o   = lacc_q;
  assign e_st_access_o   = sacc_q;
  assign wbm_addr_o      = addr_q;
  assign wbm_dat_o       = wdat_q;
  assign wbm_sel_o       = sel_q;
  assign wbm_cyc_o       = (state_q == BUS);
  assign wbm_stb_o       = (state_q == BUS);
  assign wbm_we_o        = (state_q == BUS) && we_q;

endmodule
